// File: rtl/uart_pkg.sv
// Shared types, constants and rate arithmetic for the UART receive path.
// The tick generator is kept reusable so a future transmitter can share it.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = 7;
  localparam int UART_DATA_BITS  = 8;

  // Clock divider per oversample tick; 0 flags a nonsensical rate pair.
  function automatic int uart_div(input int clock_rate, input int baud_rate);
    int div;
    if ((clock_rate <= 0) || (baud_rate <= 0)) begin
      div = 0;
    end else begin
      div = clock_rate / (baud_rate * UART_OVERSAMPLE);
    end
    return div;
  endfunction

  function automatic bit uart_div_ok(input int clock_rate, input int baud_rate);
    return (uart_div(clock_rate, baud_rate) >= 2);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake plus status pulses between the receiver and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      data_valid;
  logic                      data_ready;
  logic                      frame_error;
  logic                      overrun;
  logic                      busy;

  modport master (
    output data,
    output data_valid,
    output frame_error,
    output overrun,
    output busy,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  frame_error,
    input  overrun,
    input  busy,
    output data_ready
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick, emitted as a one-cycle clock enable every DIV clocks.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = uart_div(CLOCK_RATE, BAUD_RATE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (OVERSAMPLE != UART_OVERSAMPLE) begin : g_bad_oversample
      $error("uart_tick_gen: OVERSAMPLE must be 16");
    end
    if (!uart_div_ok(CLOCK_RATE, BAUD_RATE)) begin : g_bad_div
      $error("uart_tick_gen: CLOCK_RATE/(BAUD_RATE*16) must be at least 2");
    end
  endgenerate

  logic [CW-1:0] r_cnt;

  // Divider counter wrapping at DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == LAST) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; bytes leave on a valid/ready handshake,
// framing and overwrite problems are reported as single-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  uart_rx_if.master   bus
);

  localparam logic [3:0] MID_S  = 4'(UART_MID_SAMPLE);
  localparam logic [3:0] LAST_S = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] LAST_B = 3'(UART_DATA_BITS - 1);

  logic           w_tick;
  logic           r_rx_meta;
  logic           r_rx_s;
  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;
  logic [3:0]     r_scnt;
  logic [3:0]     w_scnt_nxt;
  logic [2:0]     r_bit_idx;
  logic [2:0]     w_bit_idx_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic [7:0]     r_data;
  logic [7:0]     w_data_nxt;
  logic           r_data_valid;
  logic           w_data_valid_nxt;
  logic           r_frame_error;
  logic           w_frame_error_nxt;
  logic           r_overrun;
  logic           w_overrun_nxt;
  logic           r_busy;
  logic           w_accept;
  logic           w_stop_hit;

  uart_tick_gen #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_accept   = r_data_valid && bus.data_ready;
  assign w_stop_hit = w_tick && (r_state == STOP) && (r_scnt == LAST_S);

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_scnt        <= 4'd0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_scnt        <= w_scnt_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_shift       <= w_shift_nxt;
      r_data        <= w_data_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_overrun     <= w_overrun_nxt;
      r_busy        <= (r_state != IDLE);
    end
  end

  // Next-state logic; a good stop both loads and keeps valid, even when accepted in the same cycle
  always_comb begin
    w_state_nxt       = r_state;
    w_scnt_nxt        = r_scnt;
    w_bit_idx_nxt     = r_bit_idx;
    w_shift_nxt       = r_shift;
    w_data_nxt        = r_data;
    w_frame_error_nxt = 1'b0;
    w_overrun_nxt     = 1'b0;
    if (w_accept) begin
      w_data_valid_nxt = 1'b0;
    end else begin
      w_data_valid_nxt = r_data_valid;
    end

    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = START;
            w_scnt_nxt  = 4'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        START: begin
          if (r_scnt == MID_S) begin
            if (!r_rx_s) begin
              w_state_nxt   = DATA;
              w_scnt_nxt    = 4'd0;
              w_bit_idx_nxt = 3'd0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_scnt_nxt = r_scnt + 4'd1;
          end
        end
        DATA: begin
          if (r_scnt == LAST_S) begin
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            w_scnt_nxt  = 4'd0;
            if (r_bit_idx == LAST_B) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
          end else begin
            w_scnt_nxt = r_scnt + 4'd1;
          end
        end
        STOP: begin
          if (w_stop_hit) begin
            w_state_nxt = IDLE;
            if (r_rx_s) begin
              w_data_nxt       = r_shift;
              w_data_valid_nxt = 1'b1;
              w_overrun_nxt    = r_data_valid && !bus.data_ready;
            end else begin
              w_frame_error_nxt = 1'b1;
            end
          end else begin
            w_scnt_nxt = r_scnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_scnt_nxt  = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign bus.data        = r_data;
  assign bus.data_valid  = r_data_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = r_busy;

endmodule
